// File: rtl/interp_seq_ctrl_if.sv
// Operand/result bundle between interp_seq_ctrl (slave side) and its
// upstream request source plus the mux_add1_b operand selector (master side).
interface interp_seq_ctrl_if #(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 19
);
    logic                        start;
    logic signed [IN_WIDTH-1:0]  E1_in;
    logic signed [IN_WIDTH-1:0]  E3_in;
    logic signed [IN_WIDTH-1:0]  E4_in;
    logic signed [OUT_WIDTH-1:0] add1_b;

    logic [2:0]                  sel;
    logic signed [IN_WIDTH-1:0]  E1;
    logic signed [IN_WIDTH-1:0]  E3;
    logic signed [IN_WIDTH-1:0]  E4;
    logic signed [IN_WIDTH:0]    reg_2E;
    logic signed [OUT_WIDTH-1:0] reg_5E;
    logic                        busy;
    logic signed [OUT_WIDTH-1:0] h_out;
    logic                        h_valid;
    logic [1:0]                  h_idx;
    logic                        done;

    modport slave (
        input  start, E1_in, E3_in, E4_in, add1_b,
        output sel, E1, E3, E4, reg_2E, reg_5E, busy, h_out, h_valid, h_idx, done
    );

    modport master (
        output start, E1_in, E3_in, E4_in, add1_b,
        input  sel, E1, E3, E4, reg_2E, reg_5E, busy, h_out, h_valid, h_idx, done
    );
endinterface

// File: rtl/interp_seq_ctrl.sv
// Interpolation sequencer: latches E1/E3/E4, walks a 9-step select program and
// accumulates mux_add1_b operands into H0..H2. `INTERP_SOFT_CLR_EN adds clr.
module interp_seq_ctrl #(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 19
) (
    input  logic clk,
    input  logic rst,
`ifdef INTERP_SOFT_CLR_EN
    input  logic clr,
`endif
    interp_seq_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, S1, S2, S3, S4, S5, S6, S7, S8, S9
    } state_e;

    state_e                      state_q, state_d;
    logic signed [IN_WIDTH-1:0]  e1_q, e1_d, e3_q, e3_d, e4_q, e4_d;
    logic signed [IN_WIDTH:0]    reg2e_q, reg2e_d, e3x2;
    logic signed [OUT_WIDTH-1:0] reg5e_q, reg5e_d, e3_ext;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d, hout_q, hout_d, sum;
    logic [1:0]                  hidx_q, hidx_d;
    logic                        hval_q, hval_d, done_q, done_d, busy_q, busy_d;
    logic                        clr_w;
    logic [2:0]                  sel;

`ifdef INTERP_SOFT_CLR_EN
    assign clr_w = clr;
`else
    assign clr_w = 1'b0;
`endif

    assign e3_ext = OUT_WIDTH'(bus.E3_in);
    assign e3x2   = {bus.E3_in, 1'b0};
    assign sum    = acc_q + bus.add1_b;

    always_comb begin
        sel = 3'b111;
        case (state_q)
            S1, S6:  sel = 3'b110;
            S2, S8:  sel = 3'b011;
            S3, S9:  sel = 3'b000;
            S4:      sel = 3'b010;
            S5:      sel = 3'b100;
            S7:      sel = 3'b001;
            default: sel = 3'b111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        e1_d    = e1_q;
        e3_d    = e3_q;
        e4_d    = e4_q;
        reg2e_d = reg2e_q;
        reg5e_d = reg5e_q;
        acc_d   = acc_q;
        hout_d  = hout_q;
        hidx_d  = hidx_q;
        hval_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        if (clr_w) begin
            state_d = IDLE;
            acc_d   = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        e1_d    = bus.E1_in;
                        e3_d    = bus.E3_in;
                        e4_d    = bus.E4_in;
                        reg2e_d = -e3x2;
                        reg5e_d = (e3_ext <<< 2) + e3_ext;
                        busy_d  = 1'b1;
                        state_d = S1;
                    end
                end
                S1: begin acc_d = bus.add1_b; state_d = S2; end
                S2: begin acc_d = sum;        state_d = S3; end
                S4: begin acc_d = bus.add1_b; state_d = S5; end
                S5: begin acc_d = sum;        state_d = S6; end
                S7: begin acc_d = bus.add1_b; state_d = S8; end
                S8: begin acc_d = sum;        state_d = S9; end
                // Group ends publish acc + the final operand directly.
                S3, S6, S9: begin
                    acc_d  = sum;
                    hout_d = sum;
                    hval_d = 1'b1;
                    if (state_q == S3) begin
                        hidx_d  = 2'd0;
                        state_d = S4;
                    end else if (state_q == S6) begin
                        hidx_d  = 2'd1;
                        state_d = S7;
                    end else begin
                        hidx_d  = 2'd2;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            e1_q    <= '0;
            e3_q    <= '0;
            e4_q    <= '0;
            reg2e_q <= '0;
            reg5e_q <= '0;
            acc_q   <= '0;
            hout_q  <= '0;
            hidx_q  <= '0;
            hval_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            e1_q    <= e1_d;
            e3_q    <= e3_d;
            e4_q    <= e4_d;
            reg2e_q <= reg2e_d;
            reg5e_q <= reg5e_d;
            acc_q   <= acc_d;
            hout_q  <= hout_d;
            hidx_q  <= hidx_d;
            hval_q  <= hval_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.sel     = sel;
    assign bus.E1      = e1_q;
    assign bus.E3      = e3_q;
    assign bus.E4      = e4_q;
    assign bus.reg_2E  = reg2e_q;
    assign bus.reg_5E  = reg5e_q;
    assign bus.busy    = busy_q;
    assign bus.h_out   = hout_q;
    assign bus.h_valid = hval_q;
    assign bus.h_idx   = hidx_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Bench for interp_seq_ctrl: closes the loop through a behavioural mux_add1_b
// and checks every program against H0..H2 computed directly from E1/E3/E4.
module tb_interp_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef INTERP_SOFT_CLR_EN
    logic clr = 1'b0;
`endif
    int vectors = 0;
    int miscompares = 0;
    logic signed [18:0] last_h = '0;

    interp_seq_ctrl_if #(.IN_WIDTH(17), .OUT_WIDTH(19)) bus ();

    interp_seq_ctrl #(.IN_WIDTH(17), .OUT_WIDTH(19)) dut (
        .clk (clk),
        .rst (rst),
`ifdef INTERP_SOFT_CLR_EN
        .clr (clr),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    // mux_add1_b operand selector
    logic signed [18:0] e1x, e3x, e4x, r2x;
    always_comb begin
        e1x = 19'(bus.E1);
        e3x = 19'(bus.E3);
        e4x = 19'(bus.E4);
        r2x = 19'(bus.reg_2E);
        case (bus.sel)
            3'b000:  bus.add1_b = 19'sd1;
            3'b001:  bus.add1_b = e3x <<< 1;
            3'b011:  bus.add1_b = e4x <<< 1;
            3'b010:  bus.add1_b = bus.reg_5E;
            3'b110:  bus.add1_b = e1x;
            3'b100:  bus.add1_b = r2x;
            default: bus.add1_b = '0;
        endcase
    end

    function automatic logic signed [18:0] w19(input longint v);
        return v[18:0];
    endfunction

    function automatic logic signed [17:0] w18(input longint v);
        return v[17:0];
    endfunction

    // Entered at the negedge right after the accept edge T0; leaves at the negedge after T9.
    task automatic check_program(input int e1, input int e3, input int e4, input string tag);
        logic signed [18:0] h [3];
        logic [2:0] prog [9];
        logic [2:0] exp_sel;
        logic [50:0] exp_e;
        bit strobe;
        int g;
        prog = '{3'b110, 3'b011, 3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b000};
        h[0] = w19(longint'(e1) + 2 * longint'(e4) + 1);
        h[1] = w19(3 * longint'(e3) + longint'(e1));
        h[2] = w19(2 * longint'(e3) + 2 * longint'(e4) + 1);
        exp_e = {17'(e1), 17'(e3), 17'(e4)};

        vectors++;
        if ({bus.E1, bus.E3, bus.E4} !== exp_e) begin
            miscompares++;
            $display("FAIL %s latch: got %h expected %h", tag, {bus.E1, bus.E3, bus.E4}, exp_e);
        end
        vectors++;
        if (bus.reg_2E !== w18(-2 * longint'(e3))) begin
            miscompares++;
            $display("FAIL %s reg_2E: got %0d expected %0d", tag, bus.reg_2E, w18(-2 * longint'(e3)));
        end
        vectors++;
        if (bus.reg_5E !== w19(5 * longint'(e3))) begin
            miscompares++;
            $display("FAIL %s reg_5E: got %0d expected %0d", tag, bus.reg_5E, w19(5 * longint'(e3)));
        end
        vectors++;
        if ({bus.busy, bus.h_valid, bus.done, bus.sel} !== {3'b100, prog[0]}) begin
            miscompares++;
            $display("FAIL %s accept ctrl: got busy/hv/done/sel %b expected %b", tag,
                     {bus.busy, bus.h_valid, bus.done, bus.sel}, {3'b100, prog[0]});
        end

        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_sel = (k == 9) ? 3'b111 : prog[k];
            strobe  = (k % 3 == 0);
            vectors++;
            if ({bus.busy, bus.h_valid, bus.done, bus.sel} !== {k < 9, strobe, k == 9, exp_sel}) begin
                miscompares++;
                $display("FAIL %s ctrl T%0d: got busy/hv/done/sel %b expected %b", tag, k,
                         {bus.busy, bus.h_valid, bus.done, bus.sel}, {k < 9, strobe, k == 9, exp_sel});
            end
            vectors++;
            if ({bus.E1, bus.E3, bus.E4} !== exp_e) begin
                miscompares++;
                $display("FAIL %s latch hold T%0d: got %h expected %h", tag, k, {bus.E1, bus.E3, bus.E4}, exp_e);
            end
            if (strobe) begin
                g = k / 3 - 1;
                last_h = h[g];
                vectors++;
                if (bus.h_idx !== 2'(g)) begin
                    miscompares++;
                    $display("FAIL %s h_idx T%0d: got %0d expected %0d", tag, k, bus.h_idx, g);
                end
            end
            vectors++;
            if (bus.h_out !== last_h) begin
                miscompares++;
                $display("FAIL %s h_out T%0d: got %0d expected %0d", tag, k, bus.h_out, last_h);
            end
        end
    endtask

    task automatic apply(input int e1, input int e3, input int e4, input string tag);
        bus.E1_in = 17'(e1);
        bus.E3_in = 17'(e3);
        bus.E4_in = 17'(e4);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_program(e1, e3, e4, tag);
    endtask

    function automatic int rnd_e();
        return int'($urandom_range(131070)) - 65535;
    endfunction

    task automatic check_zero(input string tag);
        vectors++;
        if ({bus.busy, bus.h_valid, bus.done, bus.h_idx, bus.sel} !== 8'b0000_0111) begin
            miscompares++;
            $display("FAIL %s ctrl: got busy/hv/done/idx/sel %b expected 00000111", tag,
                     {bus.busy, bus.h_valid, bus.done, bus.h_idx, bus.sel});
        end
        vectors++;
        if ({bus.E1, bus.E3, bus.E4, bus.reg_2E, bus.reg_5E, bus.h_out} !== '0) begin
            miscompares++;
            $display("FAIL %s data: got %h expected 0", tag,
                     {bus.E1, bus.E3, bus.E4, bus.reg_2E, bus.reg_5E, bus.h_out});
        end
    endtask

    task automatic test_reset();
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        last_h = '0;
    endtask

    task automatic test_basic();
        apply(10, -4, 7, "basic");
    endtask

    task automatic test_wrap();
        apply(65535, 65535, 65535, "wrap");
    endtask

    task automatic test_neg_extreme();
        apply(-65535, -65535, -65535, "neg_extreme");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) apply(rnd_e(), rnd_e(), rnd_e(), "random");
    endtask

    task automatic test_back_to_back();
        int a1, a3, a4, b1, b3, b4;
        a1 = rnd_e(); a3 = rnd_e(); a4 = rnd_e();
        b1 = rnd_e(); b3 = rnd_e(); b4 = rnd_e();
        bus.E1_in = 17'(a1);
        bus.E3_in = 17'(a3);
        bus.E4_in = 17'(a4);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.E1_in = 17'(b1);
        bus.E3_in = 17'(b3);
        bus.E4_in = 17'(b4);
        check_program(a1, a3, a4, "b2b_first");
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_program(b1, b3, b4, "b2b_second");
    endtask

    task automatic test_reset_mid();
        bus.E1_in = 17'(rnd_e());
        bus.E3_in = 17'(rnd_e());
        bus.E4_in = 17'(rnd_e());
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1 rst = 1'b1;
        #1 check_zero("reset_mid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_h = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if ({bus.busy, bus.h_valid, bus.done} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_mid quiet %0d: got busy/hv/done %b expected 000", k,
                         {bus.busy, bus.h_valid, bus.done});
            end
        end
        apply(rnd_e(), rnd_e(), rnd_e(), "after_reset");
    endtask

`ifdef INTERP_SOFT_CLR_EN
    task automatic test_soft_clr();
        int e1, e3, e4, hv_seen;
        logic signed [18:0] h0;
        e1 = rnd_e(); e3 = rnd_e(); e4 = rnd_e();
        h0 = w19(longint'(e1) + 2 * longint'(e4) + 1);
        hv_seen = 0;
        bus.E1_in = 17'(e1);
        bus.E3_in = 17'(e3);
        bus.E4_in = 17'(e4);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            hv_seen += int'(bus.h_valid);
        end
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        vectors++;
        if ({bus.busy, bus.h_valid, bus.done, bus.sel} !== 6'b000111) begin
            miscompares++;
            $display("FAIL clr ctrl: got busy/hv/done/sel %b expected 000111",
                     {bus.busy, bus.h_valid, bus.done, bus.sel});
        end
        vectors++;
        if ({bus.h_out, bus.E1} !== {h0, 17'(e1)}) begin
            miscompares++;
            $display("FAIL clr hold: got h_out/E1 %0d/%0d expected %0d/%0d", bus.h_out, bus.E1, h0, e1);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            hv_seen += int'(bus.h_valid);
        end
        vectors++;
        if (hv_seen !== 1) begin
            miscompares++;
            $display("FAIL clr strobes: got %0d expected 1", hv_seen);
        end
        bus.E1_in = 17'(rnd_e());
        bus.start = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        clr = 1'b0;
        vectors++;
        if ({bus.busy, bus.sel, bus.E1} !== {4'b0111, 17'(e1)}) begin
            miscompares++;
            $display("FAIL clr_start: got busy/sel/E1 %b/%b/%0d expected 0/111/%0d",
                     bus.busy, bus.sel, bus.E1, e1);
        end
        last_h = h0;
        apply(rnd_e(), rnd_e(), rnd_e(), "after_clr");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.E1_in = '0;
        bus.E3_in = '0;
        bus.E4_in = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_neg_extreme();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef INTERP_SOFT_CLR_EN
        test_soft_clr();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
